// File: rtl/clock_pkg.sv
// Shared types and constants for the clock field counters.
package clock_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_DIGIT_MAX = 4'd9;

  // Field maxima as tens/units digit pairs.
  localparam int unsigned SEC_MAX_M  = 5;
  localparam int unsigned SEC_MAX_L  = 9;
  localparam int unsigned MIN_MAX_M  = 5;
  localparam int unsigned MIN_MAX_L  = 9;
  localparam int unsigned HOUR_MAX_M = 2;
  localparam int unsigned HOUR_MAX_L = 3;

  // True when the two-digit value (m,l) does not exceed (max_m,max_l).
  // Digit-wise comparison keeps everything within 4 bits.
  function automatic logic bcd_le(input bcd_digit_t m, input bcd_digit_t l,
                                  input bcd_digit_t max_m, input bcd_digit_t max_l);
    return (m < max_m) || ((m == max_m) && (l <= max_l));
  endfunction

endpackage

// File: rtl/bcd_field_counter_if.sv
// Control/status bundle of one clock field counter.
interface bcd_field_counter_if;
  import clock_pkg::*;

  logic       tick_in;
  logic       dir;
  logic       load_en;
  bcd_digit_t load_l;
  bcd_digit_t load_m;
  bcd_digit_t l;
  bcd_digit_t m;
  logic       carry_out;
  logic       load_err;

  modport master (
    output tick_in, dir, load_en, load_l, load_m,
    input  l, m, carry_out, load_err
  );

  modport slave (
    input  tick_in, dir, load_en, load_l, load_m,
    output l, m, carry_out, load_err
  );

endinterface

// File: rtl/bcd_field_counter_digit_step.sv
// One BCD digit stepped up or down by one, wrapping against a limit.
// Up: wraps to 0 after reaching limit. Down: wraps from 0 to limit.
module bcd_digit_step
  import clock_pkg::*;
(
  input  bcd_digit_t digit_i,
  input  bcd_digit_t limit_i,
  input  logic       dir_i,
  output bcd_digit_t next_o,
  output logic       wrap_o
);

  // Next digit value and wrap flag for one step in the requested direction.
  always_comb begin
    next_o = digit_i;
    wrap_o = 1'b0;
    if (!dir_i) begin
      if (digit_i >= limit_i) begin
        next_o = '0;
        wrap_o = 1'b1;
      end else begin
        next_o = digit_i + 4'd1;
      end
    end else begin
      if (digit_i == '0) begin
        next_o = limit_i;
        wrap_o = 1'b1;
      end else begin
        next_o = digit_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_field_counter.sv
// Two-digit BCD counter for one clock field with up/down count,
// validated preload and a registered carry/borrow pulse.
module bcd_field_counter
  import clock_pkg::*;
#(
  parameter int unsigned MAX_M   = SEC_MAX_M,
  parameter int unsigned MAX_L   = SEC_MAX_L,
  parameter int unsigned RESET_M = 0,
  parameter int unsigned RESET_L = 0
) (
  input logic                clk,
  input logic                resett,
  bcd_field_counter_if.slave bus
);

  if (MAX_M > 9) begin : g_bad_max_m
    $error("bcd_field_counter: MAX_M must be 0..9");
  end
  if (MAX_L > 9) begin : g_bad_max_l
    $error("bcd_field_counter: MAX_L must be 0..9");
  end
  if ((RESET_L > 9) || (RESET_M > MAX_M) || ((RESET_M == MAX_M) && (RESET_L > MAX_L)))
  begin : g_bad_reset
    $error("bcd_field_counter: reset value exceeds field maximum");
  end

  localparam bcd_digit_t MAX_M_D   = bcd_digit_t'(MAX_M);
  localparam bcd_digit_t MAX_L_D   = bcd_digit_t'(MAX_L);
  localparam bcd_digit_t RESET_M_D = bcd_digit_t'(RESET_M);
  localparam bcd_digit_t RESET_L_D = bcd_digit_t'(RESET_L);

  bcd_digit_t l_q, l_d;
  bcd_digit_t m_q, m_d;
  logic       carry_q, carry_d;
  logic       err_q, err_d;

  bcd_digit_t l_lim;
  bcd_digit_t l_step, m_step;
  logic       l_wrap, m_wrap;
  logic       load_ok;

  // Units limit: counting up it is the top of the current tens value;
  // counting down it is the value loaded on a borrow, which is MAX_L only
  // when the tens digit itself wraps (from 0 to MAX_M), otherwise 9.
  always_comb begin
    l_lim = BCD_DIGIT_MAX;
    if (!bus.dir) begin
      if (m_q == MAX_M_D) l_lim = MAX_L_D;
    end else begin
      if (m_q == '0) l_lim = MAX_L_D;
    end
  end

  bcd_digit_step u_units (
    .digit_i (l_q),
    .limit_i (l_lim),
    .dir_i   (bus.dir),
    .next_o  (l_step),
    .wrap_o  (l_wrap)
  );

  bcd_digit_step u_tens (
    .digit_i (m_q),
    .limit_i (MAX_M_D),
    .dir_i   (bus.dir),
    .next_o  (m_step),
    .wrap_o  (m_wrap)
  );

  assign load_ok = (bus.load_l <= BCD_DIGIT_MAX) && (bus.load_m <= BCD_DIGIT_MAX) &&
                   bcd_le(bus.load_m, bus.load_l, MAX_M_D, MAX_L_D);

  // Next state: load beats tick; a tick only moves tens on a units wrap,
  // and the field wraps when both digits wrap together.
  always_comb begin
    l_d     = l_q;
    m_d     = m_q;
    carry_d = 1'b0;
    err_d   = 1'b0;
    if (bus.load_en) begin
      if (load_ok) begin
        l_d = bus.load_l;
        m_d = bus.load_m;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.tick_in) begin
      l_d = l_step;
      if (l_wrap) begin
        m_d     = m_step;
        carry_d = m_wrap;
      end
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (resett) begin
      l_q     <= RESET_L_D;
      m_q     <= RESET_M_D;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      l_q     <= l_d;
      m_q     <= m_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign bus.l         = l_q;
  assign bus.m         = m_q;
  assign bus.carry_out = carry_q;
  assign bus.load_err  = err_q;

endmodule

// File: tb/tb_bcd_field_counter.sv
// Bench for bcd_field_counter: vector table on an hours field, hand
// sequences on a seconds field, and a sec/min/hour chain.
module tb_bcd_field_counter;
  import clock_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bcd_field_counter_if ia ();
  bcd_field_counter_if ih ();
  bcd_field_counter_if ics ();
  bcd_field_counter_if icm ();
  bcd_field_counter_if ich ();

  bcd_field_counter #(.MAX_M(5), .MAX_L(9), .RESET_M(0), .RESET_L(0)) u_a (
    .clk(clk), .resett(rst), .bus(ia));
  bcd_field_counter #(.MAX_M(2), .MAX_L(3), .RESET_M(0), .RESET_L(0)) u_h (
    .clk(clk), .resett(rst), .bus(ih));
  bcd_field_counter #(.MAX_M(5), .MAX_L(9), .RESET_M(0), .RESET_L(0)) u_cs (
    .clk(clk), .resett(rst), .bus(ics));
  bcd_field_counter #(.MAX_M(5), .MAX_L(9), .RESET_M(0), .RESET_L(0)) u_cm (
    .clk(clk), .resett(rst), .bus(icm));
  bcd_field_counter #(.MAX_M(2), .MAX_L(3), .RESET_M(0), .RESET_L(0)) u_ch (
    .clk(clk), .resett(rst), .bus(ich));

  assign icm.tick_in = ics.carry_out;
  assign ich.tick_in = icm.carry_out;

  typedef struct packed {
    logic       sel;  // 0 = seconds DUT, 1 = hours DUT
    bcd_digit_t m;
    bcd_digit_t l;
    logic       c;
    logic       e;
  } exp_t;

  typedef struct packed {
    logic       r, tk, dr, ld;
    bcd_digit_t lm, ll;
    bcd_digit_t em, el;
    logic       ec, ee;
  } vec_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, tk, dr, ld, input int lm, ll, em, el,
                              input logic ec, ee);
    vec_t v;
    v.r = r; v.tk = tk; v.dr = dr; v.ld = ld;
    v.lm = 4'(lm); v.ll = 4'(ll); v.em = 4'(em); v.el = 4'(el);
    v.ec = ec; v.ee = ee;
    return v;
  endfunction

  // Drive one cycle of stimulus on the selected DUT and queue its expectation.
  task automatic drive(input logic sel, input logic r, tk, dr, ld,
                       input bcd_digit_t lm, ll, input exp_t e, input string tag);
    rst = r;
    ia.tick_in = 1'b0; ia.dir = 1'b0; ia.load_en = 1'b0; ia.load_m = '0; ia.load_l = '0;
    ih.tick_in = 1'b0; ih.dir = 1'b0; ih.load_en = 1'b0; ih.load_m = '0; ih.load_l = '0;
    if (sel) begin
      ih.tick_in = tk; ih.dir = dr; ih.load_en = ld; ih.load_m = lm; ih.load_l = ll;
    end else begin
      ia.tick_in = tk; ia.dir = dr; ia.load_en = ld; ia.load_m = lm; ia.load_l = ll;
    end
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Advance one clock and compare everything the scoreboard holds.
  task automatic settle_and_check();
    exp_t  e;
    string t;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      if (e.sel) begin
        chk({t, ".m"}, 8'(ih.m), 8'(e.m));
        chk({t, ".l"}, 8'(ih.l), 8'(e.l));
        chk({t, ".carry"}, 8'(ih.carry_out), 8'(e.c));
        chk({t, ".err"}, 8'(ih.load_err), 8'(e.e));
      end else begin
        chk({t, ".m"}, 8'(ia.m), 8'(e.m));
        chk({t, ".l"}, 8'(ia.l), 8'(e.l));
        chk({t, ".carry"}, 8'(ia.carry_out), 8'(e.c));
        chk({t, ".err"}, 8'(ia.load_err), 8'(e.e));
      end
    end
  endtask

  task automatic step(input logic sel, input logic r, tk, dr, ld, input int lm, ll,
                      input int em, el, input logic ec, ee, input string tag);
    exp_t e;
    e.sel = sel; e.m = 4'(em); e.l = 4'(el); e.c = ec; e.e = ee;
    drive(sel, r, tk, dr, ld, 4'(lm), 4'(ll), e, tag);
    settle_and_check();
  endtask

  localparam int NV = 24;
  vec_t vt[NV];

  initial begin
    int v;
    int hc, mc, settled;

    rst = 1'b1;
    ia.tick_in = 0; ia.dir = 0; ia.load_en = 0; ia.load_m = '0; ia.load_l = '0;
    ih.tick_in = 0; ih.dir = 0; ih.load_en = 0; ih.load_m = '0; ih.load_l = '0;
    ics.tick_in = 0; ics.dir = 0; ics.load_en = 0; ics.load_m = '0; ics.load_l = '0;
    icm.dir = 0; icm.load_en = 0; icm.load_m = '0; icm.load_l = '0;
    ich.dir = 0; ich.load_en = 0; ich.load_m = '0; ich.load_l = '0;

    //            r  tk dr ld lm ll  em el  ec ee
    vt[0]  = mk(1, 0, 0, 0, 0, 0,  0, 0,  0, 0);  // reset
    vt[1]  = mk(0, 1, 1, 0, 0, 0,  2, 3,  1, 0);  // borrow 00 -> 23
    vt[2]  = mk(0, 1, 1, 0, 0, 0,  2, 2,  0, 0);
    vt[3]  = mk(0, 0, 0, 1, 2, 0,  2, 0,  0, 0);  // load 20
    vt[4]  = mk(0, 1, 1, 0, 0, 0,  1, 9,  0, 0);  // 20 -> 19
    vt[5]  = mk(0, 0, 0, 1, 2, 3,  2, 3,  0, 0);  // load 23
    vt[6]  = mk(0, 0, 0, 1, 2, 4,  2, 3,  0, 1);  // 24 rejected
    vt[7]  = mk(0, 0, 0, 0, 0, 0,  2, 3,  0, 0);  // idle, err cleared
    vt[8]  = mk(0, 0, 0, 1, 1, 10, 2, 3,  0, 1);  // units digit 10 rejected
    vt[9]  = mk(0, 0, 0, 1, 10, 0, 2, 3,  0, 1);  // tens digit 10 rejected
    vt[10] = mk(0, 0, 0, 1, 1, 9,  1, 9,  0, 0);  // load 19
    vt[11] = mk(0, 1, 0, 0, 0, 0,  2, 0,  0, 0);
    vt[12] = mk(0, 1, 0, 0, 0, 0,  2, 1,  0, 0);
    vt[13] = mk(0, 1, 0, 0, 0, 0,  2, 2,  0, 0);
    vt[14] = mk(0, 1, 0, 0, 0, 0,  2, 3,  0, 0);
    vt[15] = mk(0, 1, 0, 0, 0, 0,  0, 0,  1, 0);  // carry 23 -> 00
    vt[16] = mk(0, 1, 0, 1, 2, 2,  2, 2,  0, 0);  // load beats tick
    vt[17] = mk(1, 1, 0, 0, 0, 0,  0, 0,  0, 0);  // reset beats tick
    vt[18] = mk(1, 0, 0, 1, 2, 4,  0, 0,  0, 0);  // reset beats bad load
    vt[19] = mk(0, 1, 0, 0, 0, 0,  0, 1,  0, 0);
    vt[20] = mk(0, 1, 1, 0, 0, 0,  0, 0,  0, 0);
    vt[21] = mk(0, 1, 1, 0, 0, 0,  2, 3,  1, 0);
    vt[22] = mk(0, 0, 0, 1, 0, 9,  0, 9,  0, 0);
    vt[23] = mk(0, 1, 0, 1, 3, 0,  0, 9,  0, 1);  // bad load drops tick

    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      step(1'b1, vt[i].r, vt[i].tk, vt[i].dr, vt[i].ld, int'(vt[i].lm), int'(vt[i].ll),
           int'(vt[i].em), int'(vt[i].el), vt[i].ec, vt[i].ee, $sformatf("H.v%0d", i));
    end

    // Seconds field: full up-count cycle through 59 and back to 00.
    step(1'b0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "A.reset");
    v = 0;
    for (int i = 1; i <= 60; i++) begin
      v = (v == 59) ? 0 : v + 1;
      step(1'b0, 0, 1, 0, 0, 0, 0, v / 10, v % 10, (v == 0), 0, $sformatf("A.up%0d", i));
    end

    // Load and tick together at 59, then reset and tick together at 30.
    step(1'b0, 0, 0, 0, 1, 5, 9, 5, 9, 0, 0, "A.load59");
    step(1'b0, 0, 1, 0, 1, 0, 5, 0, 5, 0, 0, "A.load05_tick");
    step(1'b0, 0, 0, 0, 1, 3, 0, 3, 0, 0, 0, "A.load30");
    step(1'b0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, "A.rst_tick");

    // Down-count borrows across the units digit and the whole field.
    step(1'b0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, "A.load10");
    step(1'b0, 0, 1, 1, 0, 0, 0, 0, 9, 0, 0, "A.dn09");
    step(1'b0, 0, 0, 0, 1, 5, 0, 5, 0, 0, 0, "A.load50");
    step(1'b0, 0, 1, 1, 0, 0, 0, 4, 9, 0, 0, "A.dn49");
    step(1'b0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "A.load00");
    step(1'b0, 0, 1, 1, 0, 0, 0, 5, 9, 1, 0, "A.dn59");
    step(1'b0, 0, 0, 0, 1, 6, 0, 5, 9, 0, 1, "A.load60_bad");

    // Back-to-back ticks for 25 cycles from 00.
    step(1'b0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "A.reset2");
    v = 0;
    for (int i = 1; i <= 25; i++) begin
      v = v + 1;
      step(1'b0, 0, 1, 0, 0, 0, 0, v / 10, v % 10, 0, 0, $sformatf("A.b2b%0d", i));
    end

    // Sec/min/hour chain from 23:59:58.
    drive(1'b0, 1, 0, 0, 0, '0, '0, '0, "C.reset");
    void'(sb_q.pop_back());
    void'(tag_q.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    ics.load_en = 1; ics.load_m = 4'd5; ics.load_l = 4'd8;
    icm.load_en = 1; icm.load_m = 4'd5; icm.load_l = 4'd9;
    ich.load_en = 1; ich.load_m = 4'd2; ich.load_l = 4'd3;
    @(posedge clk);
    #1;
    ics.load_en = 0; icm.load_en = 0; ich.load_en = 0;
    chk("C.load.sec", {ics.m, ics.l}, 8'h58);
    chk("C.load.min", {icm.m, icm.l}, 8'h59);
    chk("C.load.hour", {ich.m, ich.l}, 8'h23);
    ics.tick_in = 1;
    @(posedge clk);
    #1;
    chk("C.tick1.sec", {ics.m, ics.l}, 8'h59);
    chk("C.tick1.hour", {ich.m, ich.l}, 8'h23);
    @(posedge clk);
    #1;
    ics.tick_in = 0;
    hc = 0;
    mc = 0;
    settled = -1;
    for (int k = 0; k < 6; k++) begin
      if (ich.carry_out) hc++;
      if (icm.carry_out) mc++;
      if (settled < 0 && {ics.m, ics.l, icm.m, icm.l, ich.m, ich.l} == 24'h000000)
        settled = k;
      @(posedge clk);
      #1;
    end
    chk("C.settle_cycles", 8'(settled), 8'd2);
    chk("C.hour_carry_pulses", 8'(hc), 8'd1);
    chk("C.min_carry_pulses", 8'(mc), 8'd1);
    chk("C.final", {ics.m, ics.l}, 8'h00);
    chk("C.final.min", {icm.m, icm.l}, 8'h00);
    chk("C.final.hour", {ich.m, ich.l}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
